multicycle_control: RTL and testbench

Moore-style sequencing FSM for the multicycle RV32I core. It decodes the latched instruction's opcode and drives every datapath enable and mux select for each instruction phase. Outputs include the PC register's `pc_write`, instruction-register load, memory strobes and register-file write. It sits beside the PC, IR, ALU and memory interface and is the only source of `pc_write` in the core.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 177 +++++++++++++++++
 tb/tb_multicycle_control.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Groups the control FSM's datapath-facing signals into one bundle.
//   master : the control FSM. Inputs are opcode, mem_ready and branch_taken.
//            It drives every enable and select.
//   slave  : the datapath side, with the directions mirrored.
interface multicycle_control_if;
    logic [6:0] opcode;        // IR[6:0] of the latched instruction
    logic       mem_ready;     // memory finished the current access
    logic       branch_taken;  // comparator result, funct3 applied
    logic       pc_write;      // load PC from next_pc
    logic       old_pc_write;  // latch current PC into old-PC
    logic       ir_write;      // load IR from memory read data
    logic       adr_src;       // 0 = PC, 1 = ALU-out register
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;     // 00 PC, 01 old PC, 10 rs1, 11 zero
    logic [1:0] alu_src_b;     // 00 rs2, 01 imm, 10 const 4
    logic [1:0] alu_op;        // 00 add, 01 sub, 10 funct decode
    logic [1:0] result_src;    // 00 ALU-out reg, 01 MDR, 10 ALU direct
    logic       illegal;       // one-cycle pulse on an unsupported opcode
    logic       halted;        // stopped by ecall/ebreak

    modport master (
        input  opcode, mem_ready, branch_taken,
        output pc_write, old_pc_write, ir_write, adr_src, mem_read, mem_write,
               reg_write, alu_src_a, alu_src_b, alu_op, result_src, illegal, halted
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  pc_write, old_pc_write, ir_write, adr_src, mem_read, mem_write,
               reg_write, alu_src_a, alu_src_b, alu_op, result_src, illegal, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore-style sequencing FSM for the multicycle RV32I core. It decodes the
// latched opcode and drives every datapath enable and mux select per phase.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : multicycle_control_if.master (opcode/mem_ready/branch_taken in,
//           all strobes and selects out)
module multicycle_control (
    input  logic                        clock,
    input  logic                        reset,
    multicycle_control_if.master        bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
        ALU_WB, BRANCH, JAL, JALR, JALR_LINK, HALT
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clock) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state       = state;
        bus.pc_write     = 1'b0;
        bus.old_pc_write = 1'b0;
        bus.ir_write     = 1'b0;
        bus.adr_src      = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.reg_write    = 1'b0;
        bus.alu_src_a    = 2'b00;
        bus.alu_src_b    = 2'b00;
        bus.alu_op       = 2'b00;
        bus.result_src   = 2'b00;
        bus.illegal      = 1'b0;
        bus.halted       = 1'b0;

        unique case (state)
            FETCH: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                // PC+4 goes straight from the ALU into PC while the IR loads.
                if (bus.mem_ready) begin
                    bus.ir_write     = 1'b1;
                    bus.pc_write     = 1'b1;
                    bus.old_pc_write = 1'b1;
                    next_state       = DECODE;
                end
            end
            DECODE: begin
                // Precompute old PC + imm into ALU-out for branch/JAL targets.
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LOAD, OP_STORE:         next_state = MEM_ADDR;
                    OP_R:                      next_state = EXEC_R;
                    OP_I, OP_LUI, OP_AUIPC:    next_state = EXEC_I;
                    OP_BRANCH:                 next_state = BRANCH;
                    OP_JAL:                    next_state = JAL;
                    OP_JALR:                   next_state = JALR;
                    OP_SYSTEM:                 next_state = HALT;
                    default: begin
                        bus.illegal = 1'b1;
                        next_state  = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                next_state    = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                bus.adr_src  = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) next_state = MEM_WB;
            end
            MEM_WB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                next_state     = FETCH;
            end
            MEM_WRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) next_state = FETCH;
            end
            EXEC_R: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
                next_state    = ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LUI:   bus.alu_src_a = 2'b11;
                    OP_AUIPC: bus.alu_src_a = 2'b01;
                    default: begin
                        bus.alu_src_a = 2'b10;
                        bus.alu_op    = 2'b10;
                    end
                endcase
                next_state = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.pc_write  = bus.branch_taken;
                next_state    = FETCH;
            end
            JAL: begin
                // PC takes the target held in ALU-out while the ALU forms
                // old PC + 4 for the link write in ALU_WB.
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
                next_state    = ALU_WB;
            end
            JALR: begin
                bus.alu_src_a  = 2'b10;
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_write   = 1'b1;
                next_state     = JALR_LINK;
            end
            JALR_LINK: begin
                bus.alu_src_a  = 2'b01;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.reg_write  = 1'b1;
                next_state     = FETCH;
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        // While reset is asserted the state register may still hold a stale
        // mid-access state, so force everything idle for that cycle.
        if (!reset) begin
            bus.pc_write     = 1'b0;
            bus.old_pc_write = 1'b0;
            bus.ir_write     = 1'b0;
            bus.adr_src      = 1'b0;
            bus.mem_read     = 1'b0;
            bus.mem_write    = 1'b0;
            bus.reg_write    = 1'b0;
            bus.alu_src_a    = 2'b00;
            bus.alu_src_b    = 2'b00;
            bus.alu_op       = 2'b00;
            bus.result_src   = 2'b00;
            bus.illegal      = 1'b0;
            bus.halted       = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. A reference model expands each
// instruction into its expected cycle-by-cycle outputs, derived from the
// documented phase rules. The bench then drives the DUT and compares every
// cycle.
module tb_multicycle_control;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multicycle_control_if bus ();
    multicycle_control dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {
        logic       pc_write, old_pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
        logic [1:0] a, b, op, rs;
        logic       illegal, halted;
    } outs_t;

    typedef struct packed {
        logic       rst, mr, tk;
        logic [6:0] opc;
        outs_t      exp;
    } stim_t;

    typedef enum { C_LOAD, C_STORE, C_R, C_I, C_LUI, C_AUIPC, C_BR, C_JAL, C_JALR, C_SYS, C_BAD } cls_e;

    stim_t seq[$];
    outs_t obs[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1110011: return C_SYS;
            default:    return C_BAD;
        endcase
    endfunction

    task automatic push(input logic rst, input logic mr, input logic tk, input logic [6:0] opc, input outs_t e);
        stim_t s;
        s.rst = rst; s.mr = mr; s.tk = tk; s.opc = opc; s.exp = e;
        seq.push_back(s);
    endtask

    // Fetch with fst stall cycles. The opcode is random because the IR
    // holds nothing meaningful yet.
    task automatic m_fetch(input int fst);
        outs_t o = '0;
        o.mem_read = 1'b1; o.b = 2'b10; o.rs = 2'b10;
        for (int i = 0; i < fst; i++) push(1'b1, 1'b0, rb(), r7(), o);
        o.pc_write = 1'b1; o.old_pc_write = 1'b1; o.ir_write = 1'b1;
        push(1'b1, 1'b1, rb(), r7(), o);
    endtask

    task automatic m_wb(input logic [6:0] op, input logic [1:0] rs);
        outs_t o = '0;
        o.reg_write = 1'b1; o.rs = rs;
        push(1'b1, rb(), rb(), op, o);
    endtask

    // Decode and all later phases of one instruction. Non-memory phases get
    // random mem_ready, and non-branch phases get random branch_taken.
    task automatic m_body(input logic [6:0] op, input logic tk, input int mst);
        outs_t o;
        cls_e  c = classify(op);
        o = '0; o.a = 2'b01; o.b = 2'b01; o.illegal = (c == C_BAD);
        push(1'b1, rb(), rb(), op, o);
        case (c)
            C_LOAD, C_STORE: begin
                o = '0; o.a = 2'b10; o.b = 2'b01;
                push(1'b1, rb(), rb(), op, o);
                o = '0; o.adr_src = 1'b1;
                if (c == C_LOAD) o.mem_read = 1'b1; else o.mem_write = 1'b1;
                for (int i = 0; i < mst; i++) push(1'b1, 1'b0, rb(), op, o);
                push(1'b1, 1'b1, rb(), op, o);
                if (c == C_LOAD) m_wb(op, 2'b01);
            end
            C_R: begin
                o = '0; o.a = 2'b10; o.op = 2'b10;
                push(1'b1, rb(), rb(), op, o);
                m_wb(op, 2'b00);
            end
            C_I, C_LUI, C_AUIPC: begin
                o = '0; o.b = 2'b01;
                if (c == C_I) begin o.a = 2'b10; o.op = 2'b10; end
                else if (c == C_LUI) o.a = 2'b11;
                else o.a = 2'b01;
                push(1'b1, rb(), rb(), op, o);
                m_wb(op, 2'b00);
            end
            C_BR: begin
                o = '0; o.a = 2'b10; o.op = 2'b01; o.pc_write = tk;
                push(1'b1, rb(), tk, op, o);
            end
            C_JAL: begin
                o = '0; o.a = 2'b01; o.b = 2'b10; o.pc_write = 1'b1;
                push(1'b1, rb(), rb(), op, o);
                m_wb(op, 2'b00);
            end
            C_JALR: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.rs = 2'b10; o.pc_write = 1'b1;
                push(1'b1, rb(), rb(), op, o);
                o = '0; o.a = 2'b01; o.b = 2'b10; o.rs = 2'b10; o.reg_write = 1'b1;
                push(1'b1, rb(), rb(), op, o);
            end
            default: ;
        endcase
    endtask

    task automatic m_instr(input logic [6:0] op, input logic tk, input int fst, input int mst);
        m_fetch(fst);
        m_body(op, tk, mst);
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.pc_write = bus.pc_write; o.old_pc_write = bus.old_pc_write; o.ir_write = bus.ir_write;
        o.adr_src = bus.adr_src; o.mem_read = bus.mem_read; o.mem_write = bus.mem_write;
        o.reg_write = bus.reg_write; o.a = bus.alu_src_a; o.b = bus.alu_src_b; o.op = bus.alu_op;
        o.rs = bus.result_src; o.illegal = bus.illegal; o.halted = bus.halted;
        return o;
    endfunction

    // Plays the queued stimulus one cycle per entry and samples mid-cycle.
    task automatic run_seq();
        obs.delete();
        foreach (seq[i]) begin
            reset = seq[i].rst;
            bus.mem_ready = seq[i].mr;
            bus.branch_taken = seq[i].tk;
            bus.opcode = seq[i].opc;
            @(negedge clock);
            obs.push_back(sample());
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        outs_t o = '0;
        seq.delete();
        push(1'b0, rb(), rb(), r7(), o);
        push(1'b0, rb(), rb(), r7(), o);
        o.mem_read = 1'b1; o.b = 2'b10; o.rs = 2'b10;
        push(1'b1, 1'b0, rb(), r7(), o);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL reset cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_rtype();
        seq.delete();
        m_instr(7'b0110011, 1'b0, 0, 0);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL rtype cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_load_stall();
        seq.delete();
        m_instr(7'b0000011, 1'b0, 0, 2);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL load_stall cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        seq.delete();
        m_instr(7'b1100011, 1'b1, 0, 0);
        m_instr(7'b1100011, 1'b0, 0, 0);
        m_instr(7'b1100011, 1'b1, 1, 0);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL branch cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_jalr_illegal();
        seq.delete();
        m_instr(7'b1100111, 1'b0, 0, 0);
        m_instr(7'b0000000, 1'b0, 0, 0);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL jalr_illegal cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        seq.delete();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 10))
                0: op = 7'b0000011;  1: op = 7'b0100011;  2: op = 7'b0110011;
                3: op = 7'b0010011;  4: op = 7'b0110111;  5: op = 7'b0010111;
                6: op = 7'b1100011;  7: op = 7'b1101111;  8: op = 7'b1100111;
                9: op = 7'b1101111;
                default: begin
                    op = r7();
                    if (op == 7'b1110011) op = 7'b1111111;
                end
            endcase
            m_instr(op, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL random cyc %0d op %b: got %05h expected %05h", i, seq[i].opc, obs[i], seq[i].exp);
            end
        end
    endtask

    // Halt absorbs for many cycles, then a reset recovers the core.
    task automatic test_halt();
        outs_t o = '0;
        seq.delete();
        m_instr(7'b1110011, 1'b0, 0, 0);
        o.halted = 1'b1;
        for (int i = 0; i < 12; i++) push(1'b1, rb(), rb(), r7(), o);
        push(1'b0, rb(), rb(), r7(), '0);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL halt cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    // A reset lands in the middle of a stalled store. The write strobe must
    // drop in the reset cycle, and the next cycle is a plain fetch wait.
    task automatic test_reset_mid_access();
        outs_t o;
        seq.delete();
        m_fetch(0);
        o = '0; o.a = 2'b01; o.b = 2'b01;
        push(1'b1, 1'b1, 1'b0, 7'b0100011, o);
        o = '0; o.a = 2'b10; o.b = 2'b01;
        push(1'b1, 1'b1, 1'b0, 7'b0100011, o);
        o = '0; o.adr_src = 1'b1; o.mem_write = 1'b1;
        push(1'b1, 1'b0, 1'b0, 7'b0100011, o);
        push(1'b1, 1'b0, 1'b0, 7'b0100011, o);
        push(1'b0, 1'b0, 1'b0, 7'b0100011, '0);
        o = '0; o.mem_read = 1'b1; o.b = 2'b10; o.rs = 2'b10;
        push(1'b1, 1'b0, 1'b0, 7'b0100011, o);
        run_seq();
        foreach (seq[i]) begin
            checks++;
            if (obs[i] !== seq[i].exp) begin
                errors++;
                $display("FAIL reset_mid_access cyc %0d: got %05h expected %05h", i, obs[i], seq[i].exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.opcode = 7'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_rtype();
        test_load_stall();
        test_branch();
        test_jalr_illegal();
        test_random();
        test_halt();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
